// File: rtl/dcache_wb_pkg.sv
// Shared types and constants for the dcache write-back buffer.
//   ADDR_W / LINE_W / LADDR_LSB : physical address, line and line-offset geometry
//   TAG_W                       : line tag width (addr[ADDR_W-1:LADDR_LSB])
//   drain_state_e               : drain FSM states
//   wb_entry_t                  : one buffered line {valid, tag, data}
package dcache_wb_pkg;
  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 256;
  localparam int LADDR_LSB = 5;
  localparam int TAG_W     = ADDR_W - LADDR_LSB;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN_REQ  = 2'd1,
    DRAIN_WAIT = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } wb_entry_t;

  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:LADDR_LSB];
  endfunction
endpackage

// File: rtl/wb_tag_match.sv
// Parallel tag comparator over all buffer entries with age priority.
//   i_valid : per-entry eligibility (valid bit, optionally masked by caller)
//   i_tags  : per-entry line tags
//   i_tag   : tag to search for
//   i_head  : index of the oldest entry; age grows towards the tail
//   o_hit   : at least one eligible entry matches
//   o_idx   : youngest matching entry (closest to tail)
module wb_tag_match import dcache_wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [DEPTH-1:0][TAG_W-1:0]      i_tags,
  input  logic [TAG_W-1:0]                 i_tag,
  input  logic [$clog2(DEPTH)-1:0]         i_head,
  output logic                             o_hit,
  output logic [$clog2(DEPTH)-1:0]         o_idx
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] v_idx;

  // Walk from oldest to youngest; a later match overrides, so youngest wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = i_head;
    v_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = i_head + PTR_W'(k);
      if (i_valid[v_idx] && (i_tags[v_idx] == i_tag)) begin
        o_hit = 1'b1;
        o_idx = v_idx;
      end
    end
  end
endmodule

// File: rtl/dcache_write_buffer.sv
// Write-back buffer between the dcache and the memory write port.
// Holds evicted dirty lines in a coalescing FIFO, drains them one at a
// time, and serves dcache miss lookups from pending lines.
//   clk, reset                        : clock, async active-high reset
//   dcache_write_buffer_*             : evicted line from dcache (en/addr/data)
//   buffer_ready_for_dcache_write     : space available (registered state only)
//   buffer_receive_dcache_write_ok    : 1-cycle pulse after an accept
//   lookup_en/lookup_addr             : miss lookup
//   buffer_hit_success/buffer_hit_data: lookup result (data 0 on miss)
//   buffer_write_mem_*                : drain request to memory
//   mem_receive_buffer_write_ok       : memory took addr/data
//   mem_buffer_write_done             : memory write response
//   buffer_empty                      : no pending entries
module dcache_write_buffer import dcache_wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dcache_write_buffer_en,
  input  logic [ADDR_W-1:0] dcache_write_buffer_physical_addr,
  input  logic [ADDR_W-1:0] dcache_write_buffer_virtual_addr,
  input  logic [LINE_W-1:0] dcache_write_buffer_data,
  output logic              buffer_ready_for_dcache_write,
  output logic              buffer_receive_dcache_write_ok,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              buffer_hit_success,
  output logic [LINE_W-1:0] buffer_hit_data,
  output logic              buffer_write_mem_en,
  output logic [ADDR_W-1:0] buffer_write_mem_addr,
  output logic [LINE_W-1:0] buffer_write_mem_data,
  input  logic              mem_receive_buffer_write_ok,
  input  logic              mem_buffer_write_done,
  output logic              buffer_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0]       r_ent;
  logic [PTR_W-1:0]            r_head, r_tail;
  logic [PTR_W:0]              r_count;
  drain_state_e                r_state, w_state_nxt;
  logic                        r_ok;

  logic [DEPTH-1:0]            w_valid, w_coal_valid;
  logic [DEPTH-1:0][TAG_W-1:0] w_tags;
  logic [TAG_W-1:0]            w_in_tag, w_lk_tag;
  logic                        w_ready, w_accept, w_push, w_pop, w_mem_en;
  logic                        w_coal_hit, w_lk_hit, w_hit;
  logic [PTR_W-1:0]            w_coal_idx, w_lk_idx;

  // Virtual address and line-offset bits take no part in storage or matching.
  logic w_unused;
  assign w_unused = ^{dcache_write_buffer_virtual_addr,
                      dcache_write_buffer_physical_addr[LADDR_LSB-1:0],
                      lookup_addr[LADDR_LSB-1:0]};

  assign w_in_tag = line_tag(dcache_write_buffer_physical_addr);
  assign w_lk_tag = line_tag(lookup_addr);

  // The head being sent to memory must not change under the request, so it
  // is excluded from coalescing once draining starts; a same-tag line then
  // gets a fresh entry (the drained-head duplicate).
  always_comb begin
    w_valid      = '0;
    w_tags       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_tags[i]  = r_ent[i].tag;
    end
    w_coal_valid = w_valid;
    if (r_state != IDLE) w_coal_valid[r_head] = 1'b0;
  end

  wb_tag_match #(.DEPTH(DEPTH)) u_coal_match (
    .i_valid (w_coal_valid),
    .i_tags  (w_tags),
    .i_tag   (w_in_tag),
    .i_head  (r_head),
    .o_hit   (w_coal_hit),
    .o_idx   (w_coal_idx)
  );

  wb_tag_match #(.DEPTH(DEPTH)) u_lookup_match (
    .i_valid (w_valid),
    .i_tags  (w_tags),
    .i_tag   (w_lk_tag),
    .i_head  (r_head),
    .o_hit   (w_lk_hit),
    .o_idx   (w_lk_idx)
  );

  assign w_ready  = (r_count != (PTR_W+1)'(DEPTH));
  assign w_accept = dcache_write_buffer_en && w_ready;
  assign w_push   = w_accept && !w_coal_hit;

  // A line being accepted this cycle is not yet visible; a same-tag lookup
  // reports a miss until the write lands.
  assign w_hit = lookup_en && w_lk_hit && !(w_accept && (w_in_tag == w_lk_tag));

  // Drain FSM: next state and request outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE:       if (r_count != '0) w_state_nxt = DRAIN_REQ;
      DRAIN_REQ: begin
        w_mem_en = 1'b1;
        if (mem_receive_buffer_write_ok) w_state_nxt = DRAIN_WAIT;
      end
      DRAIN_WAIT: if (mem_buffer_write_done) begin
        w_pop       = 1'b1;
        w_state_nxt = IDLE;
      end
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Pop touches head, push touches tail, coalesce touches a non-head entry
  // holding the pending tag; a push implies not full, so these never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ent   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_ok <= w_accept;
      if (w_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (w_accept) begin
        if (w_coal_hit) begin
          r_ent[w_coal_idx].data <= dcache_write_buffer_data;
        end else begin
          r_ent[r_tail] <= '{valid: 1'b1, tag: w_in_tag, data: dcache_write_buffer_data};
          r_tail        <= r_tail + 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign buffer_ready_for_dcache_write  = w_ready;
  assign buffer_receive_dcache_write_ok = r_ok;
  assign buffer_empty                   = (r_count == '0);
  assign buffer_hit_success             = w_hit;
  assign buffer_hit_data                = w_hit ? r_ent[w_lk_idx].data : '0;
  assign buffer_write_mem_en            = w_mem_en;
  assign buffer_write_mem_addr          = w_mem_en ? {r_ent[r_head].tag, {LADDR_LSB{1'b0}}} : '0;
  assign buffer_write_mem_data          = w_mem_en ? r_ent[r_head].data : '0;
endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int LW    = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_paddr, wr_vaddr;
  logic [LW-1:0] wr_data;
  logic          rdy, ok;
  logic          lk_en;
  logic [AW-1:0] lk_addr;
  logic          hit;
  logic [LW-1:0] hit_data;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_data;
  logic          mem_rcv, mem_done;
  logic          empty;

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk                               (clk),
    .reset                             (reset),
    .dcache_write_buffer_en            (wr_en),
    .dcache_write_buffer_physical_addr (wr_paddr),
    .dcache_write_buffer_virtual_addr  (wr_vaddr),
    .dcache_write_buffer_data          (wr_data),
    .buffer_ready_for_dcache_write     (rdy),
    .buffer_receive_dcache_write_ok    (ok),
    .lookup_en                         (lk_en),
    .lookup_addr                       (lk_addr),
    .buffer_hit_success                (hit),
    .buffer_hit_data                   (hit_data),
    .buffer_write_mem_en               (mem_en),
    .buffer_write_mem_addr             (mem_addr),
    .buffer_write_mem_data             (mem_data),
    .mem_receive_buffer_write_ok       (mem_rcv),
    .mem_buffer_write_done             (mem_done),
    .buffer_empty                      (empty)
  );

  // Reference: pending lines in FIFO order (front = oldest) plus drain phase
  // 0 = idle, 1 = request outstanding, 2 = waiting for completion.
  typedef struct {
    logic [26:0]   tag;
    logic [LW-1:0] data;
  } line_t;

  line_t q[$];
  int    phase;
  logic  exp_ok;
  int    n_chk, n_err;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rdata();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // One clock cycle: drive inputs, check all outputs against the reference,
  // then advance the reference by the clock edge that follows.
  task automatic cyc(input logic en, input logic [AW-1:0] a, input logic [LW-1:0] d,
                     input logic lke, input logic [AW-1:0] la, input logic rv, input logic dn);
    logic          acc, xhit;
    logic [26:0]   tg, lt;
    logic [LW-1:0] xhd, xmd;
    logic [AW-1:0] xma;
    int            lj, cj, nph, sz;
    @(negedge clk);
    wr_en = en; wr_paddr = a; wr_vaddr = ~a; wr_data = d;
    lk_en = lke; lk_addr = la; mem_rcv = rv; mem_done = dn;
    #1;
    tg  = a[31:5];
    lt  = la[31:5];
    sz  = q.size();
    acc = en && (sz < DEPTH);
    lj  = -1;
    for (int j = 0; j < sz; j++) if (q[j].tag == lt) lj = j;
    xhit = lke && (lj >= 0) && !(acc && (tg == lt));
    xhd  = '0;
    if (xhit) xhd = q[lj].data;
    xma = '0; xmd = '0;
    if (phase == 1) begin
      xma = {q[0].tag, 5'b0};
      xmd = q[0].data;
    end
    check("ready",    LW'(rdy),      LW'(sz != DEPTH));
    check("empty",    LW'(empty),    LW'(sz == 0));
    check("wr_ok",    LW'(ok),       LW'(exp_ok));
    check("mem_en",   LW'(mem_en),   LW'(phase == 1));
    check("mem_addr", LW'(mem_addr), LW'(xma));
    check("mem_data", mem_data,      xmd);
    check("hit",      LW'(hit),      LW'(xhit));
    check("hit_data", hit_data,      xhd);
    // advance reference
    cj = -1;
    for (int j = (phase != 0) ? 1 : 0; j < sz; j++) if (q[j].tag == tg) cj = j;
    case (phase)
      0:       nph = (sz > 0) ? 1 : 0;
      1:       nph = rv ? 2 : 1;
      default: nph = dn ? 0 : 2;
    endcase
    if (acc && cj >= 0) q[cj].data = d;
    if (phase == 2 && dn) void'(q.pop_front());
    if (acc && cj < 0) q.push_back('{tag: tg, data: d});
    exp_ok = acc;
    phase  = nph;
  endtask

  task automatic idle(input int n, input logic rv, input logic dn);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, rv, dn);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic rv, input logic dn);
    cyc(1'b1, a, d, 1'b0, '0, rv, dn);
  endtask

  task automatic look(input logic [AW-1:0] la);
    cyc(1'b0, '0, '0, 1'b1, la, 1'b0, 1'b0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 64 && (q.size() > 0 || phase != 0); i++) idle(1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("drained", LW'(empty), LW'(1));
  endtask

  initial begin
    logic [LW-1:0] da, db, dc;
    n_chk = 0; n_err = 0;
    q.delete(); phase = 0; exp_ok = 1'b0;
    reset = 1'b1;
    wr_en = 0; wr_paddr = '0; wr_vaddr = '0; wr_data = '0;
    lk_en = 0; lk_addr = '0; mem_rcv = 0; mem_done = 0;
    #1;
    check("rst_ready",  LW'(rdy),    LW'(1));
    check("rst_empty",  LW'(empty),  LW'(1));
    check("rst_mem_en", LW'(mem_en), LW'(0));
    check("rst_ok",     LW'(ok),     LW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // single push then drain: ok at +1, request at +2, done two after accept
    push(32'h0000_1040, LW'(32'hDEAD_BEEF), 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);

    // fill with memory stalled, 5th write ignored, same-cycle pop keeps ready low
    for (int i = 0; i < 4; i++) push(32'h0001_0000 + 32'(i) * 32'h40, rdata(), 1'b0, 1'b0);
    push(32'h0001_1000, rdata(), 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    push(32'h0001_2000, rdata(), 1'b0, 1'b1);
    push(32'h0001_2000, rdata(), 1'b0, 1'b0);
    drain_all();

    // coalesce while head not yet draining
    da = rdata(); db = rdata(); dc = rdata();
    push(32'h0000_2000, da, 1'b0, 1'b0);
    push(32'h0000_2000, db, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    drain_all();

    // head draining: no coalesce, youngest copy served to lookup
    push(32'h0000_3000, da, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    push(32'h0000_3000, dc, 1'b0, 1'b0);
    look(32'h0000_3000);
    drain_all();

    // lookup with offset bits, and a miss
    push(32'h0000_4000, da, 1'b0, 1'b0);
    push(32'h0000_5000, db, 1'b0, 1'b0);
    look(32'h0000_5010);
    look(32'h0000_6000);
    cyc(1'b1, 32'h0000_7000, dc, 1'b1, 32'h0000_7000, 1'b0, 1'b0);
    look(32'h0000_7000);
    drain_all();

    // random traffic over a small tag pool
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a, la;
      a  = 32'h0000_8000 | (32'($urandom_range(5, 0)) << 5) | 32'($urandom_range(31, 0));
      la = 32'h0000_8000 | (32'($urandom_range(6, 0)) << 5) | 32'($urandom_range(31, 0));
      cyc(1'($urandom_range(1, 0)), a, rdata(), 1'($urandom_range(1, 0)), la,
          1'($urandom_range(1, 0)), ($urandom_range(9, 0) < 4));
    end
    drain_all();

    // asynchronous reset while a memory write is outstanding
    push(32'h0000_9000, rdata(), 1'b0, 1'b0);
    push(32'h0000_9040, rdata(), 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 0; lk_en = 0; mem_rcv = 0; mem_done = 0;
    #2 reset = 1'b1;
    #1;
    check("arst_mem_en", LW'(mem_en), LW'(0));
    check("arst_empty",  LW'(empty),  LW'(1));
    check("arst_ready",  LW'(rdy),    LW'(1));
    check("arst_ok",     LW'(ok),     LW'(0));
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    q.delete(); phase = 0; exp_ok = 1'b0;
    idle(3, 1'b1, 1'b1);
    push(32'h0000_A000, rdata(), 1'b1, 1'b1);
    drain_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
